// File: rtl/axi4lite_pkg.sv
// Shared AXI4-lite definitions: response codes, bus widths and the
// write/read channel state encodings used by the register slave.
package axi4lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/axi4lite_wr_collect.sv
// AW/W pairing for the AXI4-lite register slave. Accepts the address and
// data halves in either order, buffers whichever arrives first, and emits a
// single-cycle write strobe (wr_en with idx/data/strb) on the completing edge.
// Owns the B channel: bresp is latched from the caller-supplied wr_resp.
module axi4lite_wr_collect
  import axi4lite_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  aw_idx,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  output resp_t             bresp,
  input  logic              bready,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [STRB_W-1:0] wr_strb,
  input  resp_t             wr_resp
);

  wr_state_e         state_q, state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;
  logic [IDX_W-1:0]  idx_buf_q, idx_buf_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;
  logic [STRB_W-1:0] strb_buf_q, strb_buf_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;

  // Write strobe and its operands are kept out of the FSM block so the
  // external response decode (wr_idx -> wr_resp) forms no combinational loop.
  assign wr_en = ((state_q == W_IDLE)    && aw_hs && w_hs) ||
                 ((state_q == W_HAVE_AW) && w_hs) ||
                 ((state_q == W_HAVE_W)  && aw_hs);
  assign wr_idx  = (state_q == W_HAVE_AW) ? idx_buf_q  : aw_idx;
  assign wr_data = (state_q == W_HAVE_W)  ? data_buf_q : wdata;
  assign wr_strb = (state_q == W_HAVE_W)  ? strb_buf_q : wstrb;

  // Next-state, half buffering and B-channel response.
  always_comb begin
    state_d    = state_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    idx_buf_d  = idx_buf_q;
    data_buf_d = data_buf_q;
    strb_buf_d = strb_buf_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = W_RESP;
        end else if (aw_hs) begin
          idx_buf_d = aw_idx;
          state_d   = W_HAVE_AW;
        end else if (w_hs) begin
          data_buf_d = wdata;
          strb_buf_d = wstrb;
          state_d    = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)  state_d = W_RESP;
      W_HAVE_W:  if (aw_hs) state_d = W_RESP;
      W_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp;
    end
    awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_W);
    wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_AW);
  end

  // Write FSM state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      idx_buf_q  <= '0;
      data_buf_q <= '0;
      strb_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      idx_buf_q  <= idx_buf_d;
      data_buf_q <= data_buf_d;
      strb_buf_q <= strb_buf_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-lite register-file endpoint: NUM_REGS 32-bit words with byte-strobe
// writes, read-only ID word at index 0, error responses for out-of-range or
// illegal accesses, and the whole file exported flat on reg_q.
// Optional build macro AXIL_REG_DECERR_EN: out-of-range accesses answer
// DECERR instead of SLVERR (writes to the ID word always answer SLVERR).
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic [31:0]              s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [32*NUM_REGS-1:0]   reg_q
);

  localparam int unsigned IDX_W = ADDR_W - 2;

`ifdef AXIL_REG_DECERR_EN
  localparam resp_t RANGE_ERR = RESP_DECERR;
`else
  localparam resp_t RANGE_ERR = RESP_SLVERR;
`endif

  function automatic resp_t decode_resp(input logic [IDX_W-1:0] idx, input logic is_write);
    if (32'(idx) >= NUM_REGS)        return RANGE_ERR;
    else if (is_write && idx == '0)  return RESP_SLVERR;
    else                             return RESP_OKAY;
  endfunction

  // Byte offset and routed upper bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[31:ADDR_W], s_axi_awaddr[1:0],
                              s_axi_araddr[31:ADDR_W], s_axi_araddr[1:0]};

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  resp_t             wr_resp;

  assign wr_resp = decode_resp(wr_idx, 1'b1);

  axi4lite_wr_collect #(
    .IDX_W (IDX_W)
  ) u_wr_collect (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .aw_idx  (s_axi_awaddr[ADDR_W-1:2]),
    .awvalid (s_axi_awvalid),
    .awready (s_axi_awready),
    .wdata   (s_axi_wdata),
    .wstrb   (s_axi_wstrb),
    .wvalid  (s_axi_wvalid),
    .wready  (s_axi_wready),
    .bvalid  (s_axi_bvalid),
    .bresp   (s_axi_bresp),
    .bready  (s_axi_bready),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_resp (wr_resp)
  );

  // Byte-lane merge of an accepted write into the register file.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_resp == RESP_OKAY) begin
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
        if (32'(wr_idx) == k) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Register file storage.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int unsigned k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flat export; word 0 is the constant ID.
  always_comb begin
    reg_q        = '0;
    reg_q[31:0]  = ID_VALUE;
    for (int unsigned k = 1; k < NUM_REGS; k++) reg_q[32*k +: 32] = regs_q[k];
  end

  // ---------------- read channel ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rd_word;

  assign ar_idx = s_axi_araddr[ADDR_W-1:2];

  // Read mux from current (pre-write) register contents; 0 when out of range.
  always_comb begin
    rd_word = '0;
    if (ar_idx == '0) rd_word = ID_VALUE;
    for (int unsigned k = 1; k < NUM_REGS; k++) begin
      if (32'(ar_idx) == k) rd_word = regs_q[k];
    end
  end

  // Read FSM next-state and response capture.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rvalid_d   = 1'b1;
          rresp_d    = decode_resp(ar_idx, 1'b0);
          rdata_d    = rd_word;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // Read FSM state and registered channel outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with a response scoreboard and a
// reference register model kept by the bench.
module tb_axi4lite_reg_slave;

  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'hA11E_0001;
`ifdef AXIL_REG_DECERR_EN
  localparam logic [1:0]  RANGE_ERR = 2'b11;
`else
  localparam logic [1:0]  RANGE_ERR = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [32*NREG-1:0] regq;

  always #5 clk = ~clk;

  axi4lite_reg_slave #(.ADDR_W(8), .NUM_REGS(NREG), .ID_VALUE(ID)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(regq)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [NREG];
  exp_t        wq[$];
  exp_t        rq[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_wr);
    int unsigned idx = 32'(addr[7:2]);
    if (idx >= NREG)        return RANGE_ERR;
    if (is_wr && idx == 0)  return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) model[k] = '0;
    model[0] = ID;
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int unsigned idx = 32'(addr[7:2]);
    e.resp = exp_resp(addr, 1'b1);
    e.data = '0;
    if (e.resp == 2'b00)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    wq.push_back(e);
  endtask

  task automatic push_read(input logic [31:0] addr);
    exp_t e;
    int unsigned idx = 32'(addr[7:2]);
    e.resp = exp_resp(addr, 1'b0);
    e.data = (idx < NREG) ? model[idx] : 32'h0;
    rq.push_back(e);
  endtask

  task automatic pop_b(input string tag);
    exp_t e;
    if (wq.size() == 0) check({tag, "_unexpected_b"}, bvalid, 1'b0);
    else begin
      e = wq.pop_front();
      check({tag, "_bresp"}, bresp, e.resp);
    end
  endtask

  task automatic pop_r(input string tag);
    exp_t e;
    if (rq.size() == 0) check({tag, "_unexpected_r"}, rvalid, 1'b0);
    else begin
      e = rq.pop_front();
      check({tag, "_rresp"}, rresp, e.resp);
      check({tag, "_rdata"}, rdata, e.data);
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic wait_hs(input bit need_aw, input bit need_w, input bit need_ar, input string tag);
    int n = 0;
    @(negedge clk);
    while (!((!need_aw || awready) && (!need_w || wready) && (!need_ar || arready)) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_ready"}, ((!need_aw || awready) && (!need_w || wready) && (!need_ar || arready)), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic finish_b(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin n++; @(negedge clk); end
    check({tag, "_bvalid"}, bvalid, 1'b1);
    check({tag, "_blatency"}, n, 0);
    pop_b(tag);
    @(posedge clk); #1;
  endtask

  task automatic finish_r(input string tag);
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin n++; @(negedge clk); end
    check({tag, "_rvalid"}, rvalid, 1'b1);
    check({tag, "_rlatency"}, n, 0);
    pop_r(tag);
    @(posedge clk); #1;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREG; k++)
      check($sformatf("%s_word%0d", tag, k), regq[32*k +: 32], model[k]);
  endtask

  task automatic write_same(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input string tag);
    push_write(addr, data, strb);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    wait_hs(1'b1, 1'b1, 1'b0, tag);
    awvalid = 1'b0; wvalid = 1'b0;
    finish_b(tag);
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    push_read(addr);
    araddr = addr; arvalid = 1'b1;
    wait_hs(1'b0, 1'b0, 1'b1, tag);
    arvalid = 1'b0;
    finish_r(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check_regs("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b1);
    check("rel_arready", arready, 1'b1);
    @(posedge clk); #1;

    // Same-cycle AW+W, then read back
    write_same(32'h08, 32'h1234_5678, 4'hF, "wr08");
    check_regs("wr08");
    do_read(32'h08, "rd08");

    // wstrb=0 is an OKAY no-op
    write_same(32'h08, 32'hFFFF_FFFF, 4'h0, "wr08_nostrb");
    check_regs("nostrb");

    // W first, AW three cycles later
    push_write(32'h0C, 32'hAABB_CCDD, 4'b0101);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
    wait_hs(1'b0, 1'b1, 1'b0, "wfirst_w");
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wfirst_wready_low", wready, 1'b0);
      check("wfirst_awready_high", awready, 1'b1);
      check("wfirst_no_bvalid", bvalid, 1'b0);
    end
    @(posedge clk); #1;
    awaddr = 32'h0C; awvalid = 1'b1;
    wait_hs(1'b1, 1'b0, 1'b0, "wfirst_aw");
    awvalid = 1'b0;
    finish_b("wfirst");
    @(negedge clk);
    check("wfirst_single_b", bvalid, 1'b0);
    @(posedge clk); #1;
    check_regs("wfirst");
    check("word3_value", regq[3*32 +: 32], 32'h00BB_00DD);

    // ID word: read OK, write rejected
    do_read(32'h00, "rd_id");
    write_same(32'h00, 32'h5555_5555, 4'hF, "wr_id");
    check_regs("wr_id");

    // Out of range
    do_read(32'h40, "rd_oor");
    write_same(32'h40, 32'h7777_7777, 4'hF, "wr_oor");
    check_regs("wr_oor");

    // Upper and byte-offset address bits ignored (idx 9)
    write_same(32'hABCD_0127, 32'h0BAD_CAFE, 4'hF, "wr_hi_bits");
    do_read(32'h24, "rd_hi_bits");

    // Backpressure with read/write collision on word 2 (read sees pre-write)
    bready = 1'b0; rready = 1'b0;
    push_read(32'h08);
    push_write(32'h08, 32'hDEAD_BEEF, 4'hF);
    awaddr = 32'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; araddr = 32'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_hs(1'b1, 1'b1, 1'b1, "bp");
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", bvalid, 1'b1);
      check("bp_rvalid", rvalid, 1'b1);
      check("bp_bresp", bresp, wq[0].resp);
      check("bp_rresp", rresp, rq[0].resp);
      check("bp_rdata", rdata, rq[0].data);
      check("bp_awready", awready, 1'b0);
      check("bp_wready", wready, 1'b0);
      check("bp_arready", arready, 1'b0);
    end
    @(posedge clk); #1 bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    pop_b("bp_release");
    pop_r("bp_release");
    @(posedge clk);
    @(negedge clk);
    check("bp_bvalid_cleared", bvalid, 1'b0);
    check("bp_rvalid_cleared", rvalid, 1'b0);
    @(posedge clk); #1;
    check_regs("bp");
    do_read(32'h08, "rd_after_bp");

    // Reset mid-write: AW buffered, W never sent; a read response pending
    rready = 1'b0;
    awaddr = 32'h14; awvalid = 1'b1; araddr = 32'h08; arvalid = 1'b1;
    wait_hs(1'b1, 1'b0, 1'b1, "midrst");
    awvalid = 1'b0; arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bvalid", bvalid, 1'b0);
    check("midrst_rvalid", rvalid, 1'b0);
    check("midrst_awready", awready, 1'b0);
    check("midrst_wready", wready, 1'b0);
    check("midrst_arready", arready, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    model_reset();
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_bvalid", bvalid, 1'b0);
      check("postrst_no_rvalid", rvalid, 1'b0);
    end
    @(posedge clk); #1;
    check_regs("postrst");
    write_same(32'h14, 32'hCAFE_F00D, 4'hF, "wr14");
    check_regs("wr14");
    do_read(32'h14, "rd14");

    check("sb_w_empty", wq.size(), 0);
    check("sb_r_empty", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
AXI4-lite responder (register-file endpoint) that sits on one m_axi_* port of axi4lite_interconnect and answers its read/write traffic. Holds NUM_REGS 32-bit registers with byte-strobe writes and a read-only ID word at index 0. Returns an error response for out-of-range or illegal accesses. Exports the register contents as a flat bus for local logic.

Parameters:
ADDR_W, 8, local address bits decoded; upper bits ignored (the interconnect has already routed).
NUM_REGS, 16, number of 32-bit words, 2..2^(ADDR_W-2).
ID_VALUE, 32'hA11E_0001, constant returned by word 0.

Ports:
s_axi_aclk  in  1  clock, rising edge
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  32  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte lane enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_q  out  32*NUM_REGS  register contents; word k at [32k+31:32k]; word 0 = ID_VALUE

Behaviour:
- Reset (async assert, sync release): awready=wready=arready=0 during reset, 1 from the first cycle after release. bvalid=rvalid=0, bresp=rresp=0, rdata=0, registers 1..NUM_REGS-1 =0. Reset mid-transaction drops all buffered AW/W/AR and pending responses without a response.
- Decode: idx = addr[ADDR_W-1:2]; addr[1:0] ignored. idx>=NUM_REGS -> error. Write to idx 0 -> error, no state change. Error code ERR_RESP = SLVERR 2'b10 (see optional feature). OKAY = 2'b00.
- Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_W. wready=1 in W_IDLE and W_HAVE_AW. Both 0 in W_RESP.
  - AW and W accepted independently, in either order, same cycle or different cycles. The accepted half is buffered.
  - At the edge that completes the pair: register updated per wstrb (byte b written iff wstrb[b]; wstrb=0 is a legal no-op returning OKAY). At the same edge bvalid=1, bresp is set, and the FSM enters W_RESP.
  - bvalid/bresp held stable until bready. The edge with bvalid&bready returns the FSM to W_IDLE; readies are 1 in the next cycle.
  - No write outstanding beyond one.
- Read FSM: R_IDLE, R_RESP.
  - arready=1 only in R_IDLE.
  - On AR handshake: rdata = register value (ID_VALUE for idx 0; 0 on error), rresp set, rvalid=1 at the next edge (1-cycle latency). Go to R_RESP.
  - rdata/rresp/rvalid held until rready; the handshake edge returns to R_IDLE. Maximum read rate is one per 2 cycles.
- Read and write channels are fully independent. A read and a write to the same word completing at the same edge return the pre-write value.
- reg_q reflects a write from the cycle after the completing edge.
- Unused address bits [31:ADDR_W] are don't-care.

Optional Feature:
AXIL_REG_DECERR_EN: when defined, out-of-range accesses (idx>=NUM_REGS) respond DECERR 2'b11 (matches interconnect default-slave encoding). Writes to idx 0 still respond SLVERR 2'b10. When undefined, both cases respond SLVERR 2'b10.

Decomposition:
- Package axi4lite_pkg: resp typedef/constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; data width 32; strobe width 4; write/read FSM state enums.
- One natural sub-module, axi4lite_wr_collect: AW/W pairing FSM producing a single write strobe, idx and data. Read path and register array stay in the top.

Test Plan:
- Reset then AW+W same cycle, awaddr=0x08, wdata=0x1234_5678, wstrb=4'hF, bready=1 -> bvalid next cycle with bresp=00; reg_q word2=0x12345678; read 0x08 returns rdata=0x12345678, rresp=00, one cycle after AR.
- W first (wdata=0xAABB_CCDD, wstrb=4'b0101), AW 3 cycles later at 0x0C -> wready=0 while waiting; word3 becomes 0x00BB_00DD; single bvalid.
- Read 0x00 -> rdata=ID_VALUE, rresp=00. Write 0x00 -> bresp=10, ID unchanged.
- Read/write 0x40 (idx 16) -> rresp/bresp=10 with rdata=0; with AXIL_REG_DECERR_EN defined -> 11.
- Backpressure: bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stable; awready=wready=arready=0 throughout.
- Assert s_axi_aresetn low mid-write (AW buffered, W pending) -> all valids 0 immediately; after release a fresh write completes normally and word holds the new value.
